pu_vector_ctrl: RTL and testbench
=================================

Name: pu_vector_ctrl

Overview:
- Sequencer for the img2col processing-unit vector.
- Accepts a pixel stream, two pixels per beat, with a valid/ready handshake.
- Loads it row by row into the PU chain by driving the chain's start, new1/new2 and adrs_in1/adrs_in2 inputs.
- Then steps the chain through every horizontal window position with round pulses, flagging each valid window output and signalling frame completion.

Parameters:
- ROW, 28, number of PUs in the chain (image rows per band).
- IMG_W, 28, pixels per image row; must be even and ≤ 2^ADDRESS_NUM.
- KERNEL, 5, kernel width; window positions = IMG_W-KERNEL+1.
- DATA_WIDTH, 16, pixel width.
- ADDRESS_NUM, 5, PU register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse, begin a frame.
- s_valid  in  1  input beat valid.
- s_ready  out  1  controller accepts beat.
- s_data1  in  DATA_WIDTH  even-column pixel.
- s_data2  in  DATA_WIDTH  odd-column pixel.
- start  out  ROW  one-hot PU load enable.
- round  out  ROW  PU window-advance strobe.
- new1  out  DATA_WIDTH  pixel to PU, even address.
- new2  out  DATA_WIDTH  pixel to PU, odd address.
- adrs_in1  out  ADDRESS_NUM  even column address.
- adrs_in2  out  ADDRESS_NUM  odd column address.
- m_ready  in  1  downstream can take a window.
- win_valid  out  1  PU vector out holds window win_col.
- win_col  out  ADDRESS_NUM  current window column.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state = IDLE.
  - s_ready, start, round, new1, new2, adrs_in1, adrs_in2, win_valid, win_col, done, busy all 0.
  - All counters 0.
  - Reset has priority over every other event, including mid-LOAD or mid-SWEEP; a partially loaded frame is discarded.
- State machine: IDLE → LOAD → SWEEP → DONE → IDLE.
- IDLE:
  - s_ready=0.
  - On cfg_start, go to LOAD and clear row_cnt and pair_cnt.
- LOAD:
  - s_ready=1 combinationally.
  - Each accepted beat (s_valid & s_ready) registers, with one-cycle latency:
    - new1 = s_data1, new2 = s_data2.
    - adrs_in1 = 2*pair_cnt, adrs_in2 = 2*pair_cnt+1.
    - start = one-hot(row_cnt).
  - Cycles with no accepted beat drive start=0 on the next cycle; data and address outputs hold.
  - pair_cnt increments per beat and wraps at IMG_W/2-1, at which point row_cnt increments.
  - Beat with row_cnt=ROW-1 and pair_cnt=IMG_W/2-1 goes to SWEEP, and s_ready drops the next cycle.
  - Total beats accepted = ROW*IMG_W/2 (392 at defaults).
- SWEEP:
  - First cycle after LOAD (the last start pulse is visible on this cycle): win_valid=1, win_col=0, round=0.
  - On each cycle with win_valid & m_ready:
    - If win_col < IMG_W-KERNEL, drive round = all ones for exactly one cycle (the next cycle), win_valid=0 that cycle, then win_valid=1 with win_col+1.
    - If win_col = IMG_W-KERNEL, go to DONE with win_valid=0.
  - m_ready=0 holds win_valid, win_col and the PU state (round=0) indefinitely.
  - Each window therefore costs 2 cycles when never stalled.
  - Count of round pulses per frame = IMG_W-KERNEL (23 at defaults).
- DONE: done=1 for one cycle, then IDLE.
- busy is registered and equals 1 in LOAD, SWEEP and DONE.
- Simultaneous events:
  - cfg_start outside IDLE is ignored.
  - cfg_start with rst: reset wins.
  - s_valid outside LOAD is not accepted (s_ready=0).
- start and round are never asserted on the same cycle.
- start never has more than one bit set.

Test Plan:
- Reset mid-frame: rst after 100 beats → next cycle all outputs 0 and state IDLE. A fresh cfg_start then reloads from row 0, with adrs_in1=0 and start=1 on the first beat.
- Full load at defaults, s_valid held 1: exactly 392 beats accepted.
  - Beat 15 drives start=1<<1, adrs_in1=2, adrs_in2=3.
  - Last beat drives start=1<<27, adrs_in1=26, adrs_in2=27.
  - s_ready=0 afterwards.
- Bubbly input, s_valid toggling 1/0 → start pulses only on accepted beats; pair sequence unchanged; total still 392.
- Sweep with m_ready=1 → win_col 0..23 each with win_valid=1, 23 single-cycle all-ones round pulses interleaved, done exactly once, busy falls with return to IDLE.
- Sweep with m_ready=0 for 10 cycles at win_col=5 → win_col stays 5, win_valid stays 1, round stays 0; release resumes at win_col 6.
- cfg_start pulsed during LOAD and SWEEP → no restart; beat and window counts unchanged.

Source files
------------

// File: rtl/pu_vector_ctrl_if.sv
// Handshake and PU-chain bus for the img2col vector sequencer.
// slave: controller side (takes pixel stream and m_ready, drives the PU chain and window status).
// master: environment side (drives stream and m_ready, observes everything else).
interface pu_vector_ctrl_if #(
    parameter int ROW         = 28,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDRESS_NUM = 5
) ();
    logic                   cfg_start;
    logic                   s_valid;
    logic                   s_ready;
    logic [DATA_WIDTH-1:0]  s_data1;
    logic [DATA_WIDTH-1:0]  s_data2;
    logic [ROW-1:0]         start;
    logic [ROW-1:0]         round;
    logic [DATA_WIDTH-1:0]  new1;
    logic [DATA_WIDTH-1:0]  new2;
    logic [ADDRESS_NUM-1:0] adrs_in1;
    logic [ADDRESS_NUM-1:0] adrs_in2;
    logic                   m_ready;
    logic                   win_valid;
    logic [ADDRESS_NUM-1:0] win_col;
    logic                   busy;
    logic                   done;

    modport slave (
        input  cfg_start, s_valid, s_data1, s_data2, m_ready,
        output s_ready, start, round, new1, new2, adrs_in1, adrs_in2,
               win_valid, win_col, busy, done
    );

    modport master (
        output cfg_start, s_valid, s_data1, s_data2, m_ready,
        input  s_ready, start, round, new1, new2, adrs_in1, adrs_in2,
               win_valid, win_col, busy, done
    );
endinterface

// File: rtl/pu_vector_ctrl.sv
// Sequencer for the img2col PU vector: loads a frame row by row into the PU chain, then sweeps windows.
// Latency: accepted beat appears on start/new/adrs one cycle later; each unstalled window costs 2 cycles.
// Backpressure: s_ready high only while loading; m_ready low freezes the current window indefinitely.
// Ports: clk, rst (sync, active high), bus (slave modport: cfg_start, s_* stream, PU chain drive,
//        m_ready, win_valid/win_col, busy, done).
module pu_vector_ctrl #(
    parameter int ROW         = 28,
    parameter int IMG_W       = 28,
    parameter int KERNEL      = 5,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDRESS_NUM = 5
) (
    input  logic            clk,
    input  logic            rst,
    pu_vector_ctrl_if.slave bus
);
    // Column addresses are pair_cnt with the LSB appended, so the pair counter is one bit narrower.
    localparam int PW = ADDRESS_NUM - 1;
    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;

    localparam logic [PW-1:0]          PAIR_LAST = PW'(IMG_W / 2 - 1);
    localparam logic [RW-1:0]          ROW_LAST  = RW'(ROW - 1);
    localparam logic [ADDRESS_NUM-1:0] COL_LAST  = ADDRESS_NUM'(IMG_W - KERNEL);
    localparam logic [ROW-1:0]         ONE_HOT0  = ROW'(1);

    typedef enum logic [1:0] {IDLE, LOAD, SWEEP, DONE} state_t;

    state_t                 state_q;
    logic [RW-1:0]          row_cnt_q;
    logic [PW-1:0]          pair_cnt_q;
    logic [ROW-1:0]         start_q;
    logic [ROW-1:0]         round_q;
    logic [DATA_WIDTH-1:0]  new1_q;
    logic [DATA_WIDTH-1:0]  new2_q;
    logic [ADDRESS_NUM-1:0] adrs1_q;
    logic [ADDRESS_NUM-1:0] adrs2_q;
    logic                   win_valid_q;
    logic [ADDRESS_NUM-1:0] win_col_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   accept_d;

    assign bus.s_ready = (state_q == LOAD);
    assign accept_d    = (state_q == LOAD) && bus.s_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            pair_cnt_q  <= '0;
            start_q     <= '0;
            round_q     <= '0;
            new1_q      <= '0;
            new2_q      <= '0;
            adrs1_q     <= '0;
            adrs2_q     <= '0;
            win_valid_q <= 1'b0;
            win_col_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // Strobes default low; only the cycle after a qualifying event raises them.
            start_q <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cfg_start) begin
                        state_q    <= LOAD;
                        row_cnt_q  <= '0;
                        pair_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept_d) begin
                        new1_q  <= bus.s_data1;
                        new2_q  <= bus.s_data2;
                        adrs1_q <= {pair_cnt_q, 1'b0};
                        adrs2_q <= {pair_cnt_q, 1'b1};
                        start_q <= ONE_HOT0 << row_cnt_q;
                        if (pair_cnt_q == PAIR_LAST) begin
                            pair_cnt_q <= '0;
                            if (row_cnt_q == ROW_LAST) begin
                                // Window 0 is presented alongside the final start pulse.
                                state_q     <= SWEEP;
                                row_cnt_q   <= '0;
                                win_valid_q <= 1'b1;
                                win_col_q   <= '0;
                            end else begin
                                row_cnt_q <= row_cnt_q + 1'b1;
                            end
                        end else begin
                            pair_cnt_q <= pair_cnt_q + 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    if (win_valid_q) begin
                        if (bus.m_ready) begin
                            win_valid_q <= 1'b0;
                            if (win_col_q == COL_LAST) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                round_q <= '1;
                            end
                        end
                    end else begin
                        // The round pulse just shifted the chain; next window is ready.
                        win_valid_q <= 1'b1;
                        win_col_q   <= win_col_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.start     = start_q;
    assign bus.round     = round_q;
    assign bus.new1      = new1_q;
    assign bus.new2      = new2_q;
    assign bus.adrs_in1  = adrs1_q;
    assign bus.adrs_in2  = adrs2_q;
    assign bus.win_valid = win_valid_q;
    assign bus.win_col   = win_col_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_pu_vector_ctrl.sv
// Bench for pu_vector_ctrl: random stream/backpressure against a frame-level reference model.
// Latency: model predicts post-edge outputs, compared every falling edge.
// Backpressure: s_valid held/toggled/random, m_ready held/random plus a forced 10-cycle stall.
module tb_pu_vector_ctrl;
    localparam int ROW = 28, IMG_W = 28, KERNEL = 5, DW = 16, AN = 5;
    localparam int HALF = IMG_W / 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pu_vector_ctrl_if #(.ROW(ROW), .DATA_WIDTH(DW), .ADDRESS_NUM(AN)) bus ();

    pu_vector_ctrl #(.ROW(ROW), .IMG_W(IMG_W), .KERNEL(KERNEL), .DATA_WIDTH(DW),
                     .ADDRESS_NUM(AN)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame phases, beat and window indices) ----------------
    typedef enum int {P_IDLE, P_LOAD, P_SWEEP, P_DONE} phase_t;
    phase_t phase = P_IDLE;
    int     m_beats = 0;
    int     m_win = 0;
    logic   e_wv = 0, e_done = 0, e_busy = 0;
    logic [ROW-1:0] e_start = '0, e_round = '0;
    logic [DW-1:0]  e_new1 = '0, e_new2 = '0;
    int     e_a1 = 0, e_a2 = 0;
    bit     chk_en = 0;

    // observation counters for the current frame
    int fr_beats = 0, fr_rounds = 0, fr_wins = 0, fr_dones = 0;
    int acc_idx = -1;

    always @(posedge clk) begin
        logic [ROW-1:0] one;
        one = ROW'(1);
        acc_idx = -1;
        if (rst) begin
            phase = P_IDLE; m_beats = 0; m_win = 0;
            e_wv = 0; e_done = 0; e_busy = 0; e_start = '0; e_round = '0;
            e_new1 = '0; e_new2 = '0; e_a1 = 0; e_a2 = 0;
        end else begin
            if (bus.s_valid && bus.s_ready) begin
                acc_idx = fr_beats;
                fr_beats++;
            end
            if (bus.round != '0)                fr_rounds++;
            if (bus.win_valid && bus.m_ready)   fr_wins++;
            if (bus.done)                       fr_dones++;

            e_start = '0; e_round = '0; e_done = 0;
            case (phase)
                P_IDLE: if (bus.cfg_start) begin
                    phase = P_LOAD; m_beats = 0; e_busy = 1;
                end
                P_LOAD: if (bus.s_valid) begin
                    // beat k lands in row k / HALF at column pair k % HALF
                    e_new1  = bus.s_data1;
                    e_new2  = bus.s_data2;
                    e_start = one << (m_beats / HALF);
                    e_a1    = 2 * (m_beats % HALF);
                    e_a2    = e_a1 + 1;
                    m_beats++;
                    if (m_beats == ROW * HALF) begin
                        phase = P_SWEEP; m_win = 0; e_wv = 1;
                    end
                end
                P_SWEEP: begin
                    if (e_wv) begin
                        if (bus.m_ready) begin
                            e_wv = 0;
                            if (m_win == IMG_W - KERNEL) begin
                                phase = P_DONE; e_done = 1;
                            end else begin
                                e_round = '1;
                            end
                        end
                    end else begin
                        e_wv = 1; m_win++;
                    end
                end
                default: begin
                    phase = P_IDLE; e_busy = 0;
                end
            endcase
        end
        chk_en = 1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_ready",   bus.s_ready,   (phase == P_LOAD));
            chk("start",     bus.start,     e_start);
            chk("round",     bus.round,     e_round);
            chk("new1",      bus.new1,      e_new1);
            chk("new2",      bus.new2,      e_new2);
            chk("adrs_in1",  bus.adrs_in1,  64'(e_a1));
            chk("adrs_in2",  bus.adrs_in2,  64'(e_a2));
            chk("win_valid", bus.win_valid, e_wv);
            if (e_wv) chk("win_col", bus.win_col, 64'(m_win));
            chk("busy",      bus.busy,      e_busy);
            chk("done",      bus.done,      e_done);
            chk("start_onehot", 64'($countones(bus.start) <= 1), 64'd1);
            chk("start_round_excl", 64'((bus.start != '0) && (bus.round != '0)), 64'd0);
            // hand-computed anchors for the load addressing
            if (acc_idx == 0) begin
                chk("beat0_start", bus.start, 64'h1);
                chk("beat0_adrs1", bus.adrs_in1, 64'd0);
            end
            if (acc_idx == 15) begin
                chk("beat15_start", bus.start, 64'h2);
                chk("beat15_adrs1", bus.adrs_in1, 64'd2);
                chk("beat15_adrs2", bus.adrs_in2, 64'd3);
            end
            if (acc_idx == 391) begin
                chk("last_start", bus.start, 64'h800_0000);
                chk("last_adrs1", bus.adrs_in1, 64'd26);
                chk("last_adrs2", bus.adrs_in2, 64'd27);
                chk("last_s_ready", bus.s_ready, 64'd0);
                chk("last_win_valid", bus.win_valid, 64'd1);
                chk("last_win_col", bus.win_col, 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    int sv_mode = 0, mr_mode = 0;
    bit noise_en = 0, stall_arm = 0, expect6 = 0;
    int stall_cnt = 0;

    task automatic tick();
        @(negedge clk);
        bus.cfg_start = 1'b0;
        if (stall_cnt > 0) begin
            chk("stall_col",   bus.win_col,   64'd5);
            chk("stall_valid", bus.win_valid, 64'd1);
            chk("stall_round", bus.round,     64'd0);
            stall_cnt--;
        end else if (expect6 && bus.win_valid && bus.win_col != 5) begin
            chk("resume_col", bus.win_col, 64'd6);
            expect6 = 0;
        end
        if (stall_arm && bus.win_valid && bus.win_col == 5) begin
            stall_cnt = 10; stall_arm = 0; expect6 = 1;
        end
        case (sv_mode)
            0:       bus.s_valid = 1'b1;
            1:       bus.s_valid = ~bus.s_valid;
            default: bus.s_valid = 1'($urandom_range(0, 1));
        endcase
        bus.s_data1 = DW'($urandom);
        bus.s_data2 = DW'($urandom);
        if (stall_cnt > 0)     bus.m_ready = 1'b0;
        else if (mr_mode == 0) bus.m_ready = 1'b1;
        else                   bus.m_ready = ($urandom_range(0, 3) != 0);
        if (noise_en && bus.busy && $urandom_range(0, 15) == 0) bus.cfg_start = 1'b1;
    endtask

    task automatic run_frame(input int svm, input int mrm, input bit stall, input bit noise);
        bit got;
        sv_mode = svm; mr_mode = mrm; stall_arm = stall; noise_en = noise; expect6 = 0;
        fr_beats = 0; fr_rounds = 0; fr_wins = 0; fr_dones = 0;
        bus.cfg_start = 1'b1;
        got = 0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (bus.done) begin
                got = 1;
                break;
            end
        end
        chk("frame_done_seen", 64'(got), 64'd1);
        noise_en = 0;
        tick();
        tick();
        chk("frame_beats",  64'(fr_beats),  64'd392);
        chk("frame_rounds", 64'(fr_rounds), 64'd23);
        chk("frame_windows", 64'(fr_wins),  64'd24);
        chk("frame_dones",  64'(fr_dones),  64'd1);
        chk("frame_busy_low", bus.busy,     64'd0);
        if (stall) chk("stall_happened", 64'(expect6 == 0 && stall_arm == 0), 64'd1);
    endtask

    initial begin
        bit got;
        rst = 1'b1;
        bus.cfg_start = 1'b0; bus.s_valid = 1'b0; bus.m_ready = 1'b0;
        bus.s_data1 = '0; bus.s_data2 = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_busy",   bus.busy,      64'd0);
        chk("rst_start",  bus.start,     64'd0);
        chk("rst_s_ready", bus.s_ready,  64'd0);
        chk("rst_win_valid", bus.win_valid, 64'd0);
        chk("rst_done",   bus.done,      64'd0);

        // reset in the middle of a load discards the partial frame
        sv_mode = 0; mr_mode = 0; noise_en = 0; fr_beats = 0;
        bus.cfg_start = 1'b1;
        got = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (fr_beats == 100) begin
                got = 1;
                break;
            end
        end
        chk("reach_100_beats", 64'(got), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy",    bus.busy,     64'd0);
        chk("midrst_s_ready", bus.s_ready,  64'd0);
        chk("midrst_start",   bus.start,    64'd0);
        chk("midrst_new1",    bus.new1,     64'd0);
        chk("midrst_new2",    bus.new2,     64'd0);
        chk("midrst_adrs1",   bus.adrs_in1, 64'd0);
        chk("midrst_adrs2",   bus.adrs_in2, 64'd0);

        run_frame(0, 0, 0, 1);   // held s_valid, m_ready=1, cfg_start noise
        run_frame(1, 1, 1, 1);   // bubbly s_valid, random m_ready, forced stall at column 5
        run_frame(2, 1, 0, 1);   // random s_valid and m_ready

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
